// File: rtl/nmr_bstrm_seq_ctrl.sv
// Pulse-program sequencer feeding nmr_bstrm_simp_dpath: plays a preloaded entry table
// a programmable number of times through a START/DONE handshake with the datapath.
module nmr_bstrm_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MUX_WIDTH  = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int REP_WIDTH  = 16,
    localparam int ENT_W     = 1 + 4 + (MUX_WIDTH - 1) + DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [ENT_W-1:0]      prog_wdata,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic [REP_WIDTH-1:0]  rep_cnt,
    input  logic                  GO,
    input  logic                  ABORT,
    output logic                  BUSY,
    output logic                  SEQ_DONE,
    output logic [ADDR_WIDTH-1:0] cur_idx,
    output logic [REP_WIDTH-1:0]  cur_rep,
    output logic                  START,
    input  logic                  DPATH_RDY,
    input  logic                  DONE,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  PLS_POL,
    output logic [3:0]            mux_sel,
    output logic [MUX_WIDTH-2:0]  mux_in
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam int MI_LO = DATA_WIDTH;
    localparam int MS_LO = DATA_WIDTH + MUX_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LOAD     = 3'd2,
        WAIT_RDY = 3'd3,
        RUN      = 3'd4,
        NEXT     = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [ENT_W-1:0]      mem [DEPTH];
    logic [ENT_W-1:0]      ram_q;

    logic [ADDR_WIDTH:0]   len_reg, len_next;
    logic [REP_WIDTH-1:0]  reps_reg, reps_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
    logic [REP_WIDTH-1:0]  rep_reg, rep_next;
    logic                  start_reg, start_next;
    logic                  seq_done_reg, seq_done_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  pol_reg, pol_next;
    logic [3:0]            sel_reg, sel_next;
    logic [MUX_WIDTH-2:0]  min_reg, min_next;

    logic                  busy;
    logic                  go_ok;
    logic                  more_idx;
    logic                  more_rep;
    logic [ADDR_WIDTH:0]   len_clamped;

    assign busy        = (state_reg != IDLE);
    assign go_ok       = (prog_len != '0) && (rep_cnt != '0);
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign more_idx    = ({1'b0, idx_reg} < (len_reg - 1'b1));
    assign more_rep    = (rep_reg < (reps_reg - 1'b1));

    // Table storage is left out of reset so it maps onto block RAM and survives RST.
    always_ff @(posedge CLK) begin
        if (prog_we && !busy)
            mem[prog_addr] <= prog_wdata;
        if (state_reg == FETCH)
            ram_q <= mem[idx_reg];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            reps_reg     <= '0;
            idx_reg      <= '0;
            rep_reg      <= '0;
            start_reg    <= 1'b0;
            seq_done_reg <= 1'b0;
            data_reg     <= '0;
            pol_reg      <= 1'b0;
            sel_reg      <= '0;
            min_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            reps_reg     <= reps_next;
            idx_reg      <= idx_next;
            rep_reg      <= rep_next;
            start_reg    <= start_next;
            seq_done_reg <= seq_done_next;
            data_reg     <= data_next;
            pol_reg      <= pol_next;
            sel_reg      <= sel_next;
            min_reg      <= min_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:     if (GO && go_ok) state_next = FETCH;
            FETCH:    state_next = LOAD;
            LOAD:     state_next = WAIT_RDY;
            WAIT_RDY: if (DPATH_RDY) state_next = RUN;
            RUN:      if (DONE) state_next = NEXT;
            NEXT:     state_next = (more_idx || more_rep) ? FETCH : IDLE;
            default:  state_next = IDLE;
        endcase
        if (ABORT && busy)
            state_next = IDLE;
    end

    always_comb begin
        len_next      = len_reg;
        reps_next     = reps_reg;
        idx_next      = idx_reg;
        rep_next      = rep_reg;
        start_next    = start_reg;
        seq_done_next = 1'b0;
        data_next     = data_reg;
        pol_next      = pol_reg;
        sel_next      = sel_reg;
        min_next      = min_reg;
        // Abort freezes everything except START so the dpath sees a clean stop.
        if (ABORT && busy) begin
            start_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (GO) begin
                        len_next  = len_clamped;
                        reps_next = rep_cnt;
                        if (go_ok) begin
                            idx_next = '0;
                            rep_next = '0;
                        end else begin
                            seq_done_next = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    data_next = ram_q[DATA_WIDTH-1:0];
                    min_next  = ram_q[MS_LO-1:MI_LO];
                    sel_next  = ram_q[MS_LO+3:MS_LO];
                    pol_next  = ram_q[ENT_W-1];
                end
                WAIT_RDY: if (DPATH_RDY) start_next = 1'b1;
                RUN:      if (DONE) start_next = 1'b0;
                NEXT: begin
                    if (more_idx) begin
                        idx_next = idx_reg + 1'b1;
                    end else if (more_rep) begin
                        idx_next = '0;
                        rep_next = rep_reg + 1'b1;
                    end else begin
                        seq_done_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY     = busy;
    assign SEQ_DONE = seq_done_reg;
    assign cur_idx  = idx_reg;
    assign cur_rep  = rep_reg;
    assign START    = start_reg;
    assign data     = data_reg;
    assign PLS_POL  = pol_reg;
    assign mux_sel  = sel_reg;
    assign mux_in   = min_reg;

endmodule
